// File: rtl/seg7_timer.sv
// BCD up/down timer with prescaled tick, optional mm:ss digit limits and a
// registered seven-segment decode of every digit.
module seg7_timer #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int DIGITS     = 6,
    parameter int MODE       = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  running,
    output logic                  tick,
    output logic                  wrap,
    output logic                  done
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [6:0]    ZERO_SEG = (ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       presc, presc_n;
    logic [4*DIGITS-1:0] bcd_n, bcd_inc, bcd_dec, load_fix;
    logic [7*DIGITS-1:0] hex_n;
    logic                tick_n, wrap_n;
    logic                carry, borrow;

    function automatic logic [3:0] dmax(input int unsigned i);
        return (MODE == 1 && (i == 1 || i == 3)) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h3F;
        endcase
        return (ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    // Ripple increment/decrement, load sanitising and segment decode per digit
    always_comb begin
        carry    = 1'b1;
        borrow   = 1'b1;
        bcd_inc  = bcd;
        bcd_dec  = bcd;
        load_fix = load_val;
        hex_n    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == dmax(i)) begin
                    bcd_inc[4*i +: 4] = '0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = dmax(i);
                end else begin
                    bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > dmax(i)) begin
                load_fix[4*i +: 4] = '0;
            end
            hex_n[7*i +: 7] = seg(bcd[4*i +: 4]);
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        bcd_n   = bcd;
        tick_n  = 1'b0;
        wrap_n  = 1'b0;
        if (clear) begin
            bcd_n   = '0;
            presc_n = '0;
            state_n = IDLE;
        end else if (load) begin
            bcd_n   = load_fix;
            presc_n = '0;
            state_n = IDLE;
        end else if (stop) begin
            if (state == RUN) begin
                state_n = IDLE;
            end
        end else if (start && state != RUN) begin
            state_n = RUN;
        end else if (state == RUN) begin
            if (presc == PRE_LAST) begin
                presc_n = '0;
                tick_n  = 1'b1;
                if (!dir) begin
                    bcd_n  = bcd_inc;
                    wrap_n = (bcd_inc == '0);
                end else if (bcd == '0) begin
                    state_n = DONE;
                end else begin
                    bcd_n = bcd_dec;
                    if (bcd_dec == '0) begin
                        state_n = DONE;
                    end
                end
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= IDLE;
            presc <= '0;
            bcd   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            hex   <= {DIGITS{ZERO_SEG}};
        end else begin
            state <= state_n;
            presc <= presc_n;
            bcd   <= bcd_n;
            tick  <= tick_n;
            wrap  <= wrap_n;
            hex   <= hex_n;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_seg7_timer.sv
// Scoreboard bench: two timers (2-digit decimal, 4-digit mm:ss) driven by shared
// controls and checked against an integer-valued reference model.
module tb_seg7_timer;

    localparam int DIV    = 10;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic        clk = 1'b0;
    logic        clrn, start, stop, clear, load, dir;
    logic [15:0] load_val;

    logic [7:0]  bcd_a;
    logic [13:0] hex_a;
    logic        run_a, tick_a, wrap_a, done_a;
    logic [15:0] bcd_b;
    logic [27:0] hex_b;
    logic        run_b, tick_b, wrap_b, done_b;

    always #5 clk = ~clk;

    seg7_timer #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODE(0), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .clrn(clrn), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val[7:0]), .dir(dir), .bcd(bcd_a), .hex(hex_a),
        .running(run_a), .tick(tick_a), .wrap(wrap_a), .done(done_a)
    );

    seg7_timer #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(4), .MODE(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .clrn(clrn), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .dir(dir), .bcd(bcd_b), .hex(hex_b),
        .running(run_b), .tick(tick_b), .wrap(wrap_b), .done(done_b)
    );

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic        wrap;
        logic        running;
        logic        done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   v[2], pre[2], st[2], mh[2];
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Count is held as a plain integer: 0..99, or seconds-of-hour 0..3599 for mm:ss
    function automatic int modulus(input int id);
        return (id == 0) ? 100 : 3600;
    endfunction

    function automatic int dig_max(input int id, input int i);
        return (id == 1 && (i == 1 || i == 3)) ? 5 : 9;
    endfunction

    function automatic logic [15:0] to_bcd(input int id, input int val);
        int hi, lo;
        if (id == 0) return {8'h00, 4'(val / 10), 4'(val % 10)};
        hi = val / 60;
        lo = val % 60;
        return {4'(hi / 10), 4'(hi % 10), 4'(lo / 10), 4'(lo % 10)};
    endfunction

    function automatic int from_load(input int id, input logic [15:0] lv);
        int d[4];
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(lv[4*i +: 4]);
            if (d[i] > dig_max(id, i)) d[i] = 0;
        end
        if (id == 0) return d[1] * 10 + d[0];
        return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    endfunction

    function automatic logic [6:0] seg_al(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F; default: s = 7'h00;
        endcase
        return ~s;
    endfunction

    function automatic logic [27:0] hex_exp(input int id, input int val);
        logic [15:0] b;
        logic [27:0] h;
        b = to_bcd(id, val);
        for (int i = 0; i < 4; i++) h[7*i +: 7] = seg_al(b[4*i +: 4]);
        if (id == 0) h[27:14] = '0;
        return h;
    endfunction

    task automatic model_edge();
        cycle++;
        for (int id = 0; id < 2; id++) begin
            exp_t e;
            bit   tk;
            tk     = 1'b0;
            e.wrap = 1'b0;
            mh[id] = clrn ? v[id] : 0;
            if (!clrn || clear) begin
                v[id] = 0; pre[id] = 0; st[id] = S_IDLE;
            end else if (load) begin
                v[id] = from_load(id, load_val); pre[id] = 0; st[id] = S_IDLE;
            end else if (stop) begin
                if (st[id] == S_RUN) st[id] = S_IDLE;
            end else if (start && st[id] != S_RUN) begin
                st[id] = S_RUN;
            end else if (st[id] == S_RUN) begin
                if (pre[id] == DIV - 1) begin
                    pre[id] = 0;
                    tk = 1'b1;
                    if (!dir) begin
                        v[id]  = (v[id] + 1) % modulus(id);
                        e.wrap = (v[id] == 0);
                    end else if (v[id] == 0) begin
                        st[id] = S_DONE;
                    end else begin
                        v[id] = v[id] - 1;
                        if (v[id] == 0) st[id] = S_DONE;
                    end
                end else begin
                    pre[id]++;
                end
            end
            if (tk) begin
                e.cyc     = cycle;
                e.bcd     = to_bcd(id, v[id]);
                e.running = (st[id] == S_RUN);
                e.done    = (st[id] == S_DONE);
                if (id == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic check_dut(input int id, input logic [15:0] b, input logic [27:0] h,
                             input logic r, input logic dn, input logic tk, input logic wp);
        exp_t e;
        checks++;
        if (b !== to_bcd(id, v[id]) || h !== hex_exp(id, mh[id]) || r !== (st[id] == S_RUN) ||
            dn !== (st[id] == S_DONE) || (wp === 1'b1 && tk !== 1'b1)) begin
            errors++;
            $display("FAIL state dut%0d cyc %0d: got bcd=%h hex=%h run=%b done=%b tick=%b wrap=%b; want bcd=%h hex=%h run=%b done=%b",
                     id, cycle, b, h, r, dn, tk, wp, to_bcd(id, v[id]), hex_exp(id, mh[id]),
                     st[id] == S_RUN, st[id] == S_DONE);
        end
        if (tk === 1'b1) begin
            checks++;
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL tick dut%0d cyc %0d: got unexpected tick, want none", id, cycle);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                if (e.cyc != cycle || e.bcd !== b || e.wrap !== wp || e.running !== r || e.done !== dn) begin
                    errors++;
                    $display("FAIL tick dut%0d: got cyc=%0d bcd=%h wrap=%b run=%b done=%b; want cyc=%0d bcd=%h wrap=%b run=%b done=%b",
                             id, cycle, b, wp, r, dn, e.cyc, e.bcd, e.wrap, e.running, e.done);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, {8'h00, bcd_a}, {14'h0, hex_a}, run_a, done_a, tick_a, wrap_a);
            check_dut(1, bcd_b, hex_b, run_b, done_b, tick_b, wrap_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_clk();
    endtask

    task automatic pulse(input logic s, input logic sp, input logic cl, input logic ld,
                         input logic [15:0] lv);
        start = s; stop = sp; clear = cl; load = ld; load_val = lv;
        tick_clk();
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        dir = 1'b0; load_val = '0;
        idle(2);
        mon_en = 1'b1;
        chk("reset_bcd", {16'h0, bcd_a, 8'h0}, 32'h0);
        chk("reset_hex", {4'h0, hex_b}, {4'h0, {4{7'b1000000}}});
        clrn = 1'b1;
        idle(2);

        // up count, two ticks
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(25);
        // rollover 99 -> 00 keeps running
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0099);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(12);
        chk("wrap_running", {31'h0, run_a}, 32'h1);
        // count down to zero and hold
        dir = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(60);
        chk("down_done", {bcd_a, 22'h0, done_a, run_a}, {8'h00, 22'h0, 1'b1, 1'b0});
        // mm:ss carry 09:59 -> 10:00, then immediate done from 0000
        dir = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0959);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(11);
        chk("mmss_carry", {16'h0, bcd_b}, 32'h1000);
        dir = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(11);
        chk("zero_done", {bcd_b, 15'h0, done_b}, {16'h0000, 15'h0, 1'b1});
        // stop on the terminal cycle, resume one cycle from the step
        dir = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(9);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick_clk();
        chk("resume_step", {24'h0, bcd_a}, 32'h01);
        idle(3);
        // reset mid-run from 57
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0057);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(5);
        clrn = 1'b0;
        tick_clk();
        clrn = 1'b1;
        chk("rst_bcd", {24'h0, bcd_a}, 32'h00);
        chk("rst_hex", {18'h0, hex_a}, {18'h0, 7'b1000000, 7'b1000000});
        chk("rst_status", {28'h0, run_a, tick_a, wrap_a, done_a}, 32'h0);
        tick_clk();
        chk("rst_after", {30'h0, tick_a, wrap_a}, 32'h0);
        pulse(1'b1, 1'b0, 1'b1, 1'b1, 16'h0057);
        chk("clear_wins", {bcd_a, 23'h0, run_a}, 32'h0);
        idle(3);

        for (int k = 0; k < 3000; k++) begin
            int r;
            r        = $urandom_range(0, 199);
            clrn     = (r != 0);
            clear    = (r == 1);
            load     = (r >= 2 && r <= 4);
            stop     = (r >= 5 && r <= 7);
            start    = (r >= 8 && r <= 27);
            load_val = 16'($urandom);
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            tick_clk();
        end
        clrn = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        idle(2);
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_timer.md
SEG7_TIMER -- requirements
Module: seg7_timer

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter TICK_HZ, default 1, count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL provide parameter DIGITS, default 6, number of BCD digits; legal range 1..8.
REQ-004 SHALL provide parameter MODE, default 0; 0 = plain decimal, 1 = clock (digits 1 and 3 count 0..5, so digit pairs 1:0 and 3:2 count 00..59).
REQ-005 SHALL provide parameter ACTIVE_LOW, default 1; 1 = segment lit when bit is 0.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 clrn  in  1  reset; one clock; reset is synchronous and active-low.
REQ-008 start  in  1  level sampled each cycle; enters RUN.
REQ-009 stop  in  1  level sampled each cycle; leaves RUN for IDLE.
REQ-010 clear  in  1  zeroes count and prescaler, enters IDLE.
REQ-011 load  in  1  loads load_val, zeroes prescaler, enters IDLE.
REQ-012 load_val  in  4*DIGITS  BCD value, digit 0 in bits [3:0].
REQ-013 dir  in  1  0 = count up, 1 = count down; sampled on each tick.
REQ-014 bcd  out  4*DIGITS  current count, registered.
REQ-015 hex  out  7*DIGITS  segments {g,f,e,d,c,b,a} per digit, digit 0 in bits [6:0].
REQ-016 running  out  1  high in RUN.
REQ-017 tick  out  1  one-cycle pulse when the count changes.
REQ-018 wrap  out  1  one-cycle pulse on up-count rollover to all zeros.
REQ-019 done  out  1  high in DONE.

Function
REQ-020 SHALL implement states IDLE, RUN, DONE.
REQ-021 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in RUN; it holds in IDLE and DONE and is zeroed by clear, load and reset.
REQ-022 At the edge where the prescaler is at its terminal value in RUN, the prescaler SHALL return to 0 and bcd SHALL step by one; tick SHALL be high in the following cycle, coincident with the new bcd.
REQ-023 Up step: ripple BCD increment; a digit at its maximum (9, or 5 for digits 1 and 3 when MODE=1) returns to 0 and carries.
REQ-024 Up step from all-maximum SHALL give all zeros, pulse wrap with tick, and stay in RUN.
REQ-025 Down step: ripple BCD decrement; a digit at 0 borrows and reloads its maximum.
REQ-026 A down step that yields all zeros SHALL enter DONE; running goes low and done goes high in the same cycle as tick.
REQ-027 In RUN with dir=1 and bcd already all zeros, the next tick SHALL leave bcd unchanged and enter DONE.
REQ-028 Input priority each cycle: clear > load > stop > start.
REQ-029 stop in the same cycle as a prescaler terminal SHALL win: no step, no tick, enter IDLE, prescaler holds its value.
REQ-030 start in IDLE SHALL enter RUN and resume from the held prescaler value; start in DONE SHALL enter RUN; start in RUN has no effect.
REQ-031 load SHALL replace any digit above its maximum with 0.
REQ-032 hex SHALL decode each digit as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (active-high); the result is inverted when ACTIVE_LOW=1.
REQ-033 hex SHALL be a registered decode of bcd, lagging bcd by one cycle.

Reset
REQ-034 On a clk edge with clrn=0: state IDLE, prescaler 0, bcd 0, running/tick/wrap/done 0.
REQ-035 On that same edge, hex SHALL take the encoding of all "0" digits (7'b1000000 per digit when ACTIVE_LOW=1).
REQ-036 Reset SHALL abort RUN or DONE immediately; no tick or wrap pulse SHALL be produced on the reset edge or the cycle after.

Verification
REQ-037 CLK_HZ=10, TICK_HZ=1, DIGITS=2, MODE=0, dir=0: start pulse -> bcd 01 after 10 cycles and 02 after 20; tick high for exactly one cycle each.
REQ-038 Same config, load 99, then start -> after 10 cycles bcd 00, wrap and tick high one cycle, running stays 1.
REQ-039 Same config, load 03, dir=1, start -> bcd 02, 01, 00 at 10-cycle intervals; at 00 done=1, running=0; bcd holds 00 for 30 more cycles.
REQ-040 MODE=1, DIGITS=4, load 0959, dir=0, start -> next tick bcd 1000; load 0000, dir=1 -> start then tick gives done immediately with bcd 0000.
REQ-041 Stop asserted on the terminal cycle -> no step; start 3 cycles later -> next step after the remaining prescaler count (1 cycle), not 10.
REQ-042 clrn low for one cycle mid-RUN with bcd 57 -> next cycle bcd 00, hex 7'b1000000 per digit (ACTIVE_LOW=1), all status outputs 0; clear+load+start together -> bcd 00, IDLE.
